// File: rtl/softsign_out_buffer.sv
// Output buffer for the Softsign operator: absorbs a valid-only stream into a FIFO, re-emits it valid/ready with frame tags.
// Latency 1 cycle when empty; upstream cannot be stalled, so a push into a full FIFO is dropped (optional stats: SOFTSIGN_OUT_BUFFER_STATS_EN).
module softsign_out_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [DATA_W-1:0]        input_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        output_data,
  output logic                     frame_last,
  input  logic [CNT_W-1:0]         frame_len,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr
`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              empty, full, pop, push, drop, last_c;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_W'(DEPTH));
  assign pop   = !empty && out_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push  = valid_in && (!full || pop);
  assign drop  = valid_in && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    af_d     = (level_d >= LVL_W'(AF_THRESH));
    ovf_d    = drop | (ovf_q & ~ovf_clr);
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= input_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
    end
  end

  // In IDLE the head opens a new frame, so its length is the live frame_len.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    last_c  = 1'b0;
    case (state_q)
      IDLE: begin
        last_c = (frame_len == CNT_W'(1));
        if (pop) begin
          len_d = frame_len;
          if (last_c) begin
            cnt_d = '0;
          end else begin
            state_d = STREAM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      STREAM: begin
        last_c = (len_q != '0) && (cnt_q == len_q - CNT_W'(1));
        if (pop) begin
          if (last_c) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid   = !empty;
  assign output_data = empty ? hold_q : mem_q[rd_ptr_q];
  assign frame_last  = !empty && last_c;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;

`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = ovf_clr ? 16'd0 : drop_cnt_q;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_softsign_out_buffer.sv
// Scoreboard bench for softsign_out_buffer: expected words queued at push, compared at pop.
module tb_softsign_out_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] input_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] output_data;
  logic        frame_last;
  logic [15:0] frame_len = '0;
  logic        almost_full;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr = 1'b0;
`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
  logic [15:0] drop_count;
`endif

  softsign_out_buffer dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .input_data(input_data),
    .out_valid(out_valid), .out_ready(out_ready), .output_data(output_data),
    .frame_last(frame_last), .frame_len(frame_len), .almost_full(almost_full),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
    , .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sb[$];
  logic        m_stream;
  logic [15:0] m_cnt;
  logic [15:0] m_len;

  // Reference framing model, advanced once per expected pop.
  function automatic logic model_last(input logic [15:0] flen);
    logic l;
    if (!m_stream) begin
      l = (flen == 16'd1);
      if (!l) begin
        m_stream = 1'b1;
        m_cnt    = 16'd1;
        m_len    = flen;
      end
    end else begin
      l = (m_len != 16'd0) && (m_cnt == m_len - 16'd1);
      if (l) begin
        m_stream = 1'b0;
        m_cnt    = 16'd0;
      end else begin
        m_cnt = m_cnt + 16'd1;
      end
    end
    return l;
  endfunction

  // One clock: drive at negedge, sample head before the edge, queue accepted pushes.
  task automatic cyc(input logic vin, input logic [31:0] din, input logic rdy, input logic clr,
                     output logic popped, output logic pvld, output logic [31:0] pdat,
                     output logic plast);
    valid_in   = vin;
    input_data = din;
    out_ready  = rdy;
    ovf_clr    = clr;
    #1;
    pvld   = out_valid;
    pdat   = output_data;
    plast  = frame_last;
    popped = (sb.size() != 0) && rdy;
    if (vin && (sb.size() < DEPTH || popped)) sb.push_back(din);
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic reset_dut();
    valid_in = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (level !== 5'd0 || out_valid !== 1'b0 || output_data !== 32'd0 || frame_last !== 1'b0 ||
        almost_full !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state lvl=%0d vld=%b dat=%h last=%b af=%b ovf=%b, want all 0",
               level, out_valid, output_data, frame_last, almost_full, overflow);
    end
`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
    vectors++;
    if (drop_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_drop_count got=%0d want=0", drop_count);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    m_stream = 1'b0;
    m_cnt = '0;
    m_len = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_dut();
    repeat (2) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset vld=%b lvl=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_pass_through();
    logic p, v, l;
    logic [31:0] d, e;
    reset_dut();
    frame_len = 16'd0;
    cyc(1'b1, 32'h3F00_0000, 1'b1, 1'b0, p, v, d, l);
    vectors++;
    if (out_valid !== 1'b1 || output_data !== 32'h3F00_0000 || level !== 5'd1) begin
      miscompares++;
      $display("FAIL pt_latency vld=%b dat=%h lvl=%0d want 1/3f000000/1", out_valid, output_data, level);
    end
    cyc(1'b1, 32'hBF00_0000, 1'b1, 1'b0, p, v, d, l);
    if (p) begin
      e = sb.pop_front();
      vectors++;
      if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
        miscompares++;
        $display("FAIL pt_pop1 vld=%b dat=%h want %h", v, d, e);
      end
    end
    vectors++;
    if (level !== 5'd1 || output_data !== 32'hBF00_0000) begin
      miscompares++;
      $display("FAIL pt_second lvl=%0d dat=%h want 1/bf000000", level, output_data);
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
    if (p) begin
      e = sb.pop_front();
      vectors++;
      if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
        miscompares++;
        $display("FAIL pt_pop2 vld=%b dat=%h want %h", v, d, e);
      end
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0 || output_data !== 32'hBF00_0000) begin
      miscompares++;
      $display("FAIL pt_empty_hold vld=%b lvl=%0d dat=%h want 0/0/bf000000", out_valid, level, output_data);
    end
  endtask

  task automatic test_fill_overflow();
    logic p, v, l;
    logic [31:0] d, e;
    reset_dut();
    frame_len = 16'd4;
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 32'hA000_0000 + i, 1'b0, 1'b0, p, v, d, l);
      vectors++;
      if (almost_full !== (i + 1 >= 12) || level !== 5'(i + 1)) begin
        miscompares++;
        $display("FAIL fill_af push=%0d af=%b lvl=%0d want %b/%0d", i + 1, almost_full, level, (i + 1 >= 12), i + 1);
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_no_ovf ovf=%b want 0", overflow);
    end
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, p, v, d, l);
    vectors++;
    if (overflow !== 1'b1 || level !== 5'd16 || output_data !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL drop ovf=%b lvl=%0d head=%h want 1/16/a0000000", overflow, level, output_data);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL fill_drain idx=%0d dat=%h last=%b want %h", i, d, l, e);
        end
      end
    end
    vectors++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drained lvl=%0d vld=%b ovf=%b want 0/0/1", level, out_valid, overflow);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1, p, v, d, l);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clr ovf=%b want 0", overflow);
    end
  endtask

  task automatic test_full_simul();
    logic p, v, l;
    logic [31:0] d, e;
    reset_dut();
    frame_len = 16'd0;
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'hB000_0000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hC000_0000 + i, 1'b1, 1'b0, p, v, d, l);
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL full_rw_pop idx=%0d dat=%h want %h", i, d, e);
        end
      end
      vectors++;
      if (level !== 5'd16 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL full_rw_level idx=%0d lvl=%0d ovf=%b want 16/0", i, level, overflow);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL full_rw_drain idx=%0d dat=%h want %h", i, d, e);
        end
      end
    end
  endtask

  task automatic test_framing(input logic change_len, input logic [6:0] want_bits);
    logic p, v, l;
    logic [31:0] d, e;
    logic [6:0] bits;
    reset_dut();
    frame_len = 16'd3;
    bits = '0;
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h0000_1000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int k = 0; k < 7; k++) begin
      if (change_len && k == 3) frame_len = 16'd2;
      cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
      bits[k] = l;
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL frame_word chg=%b idx=%0d dat=%h last=%b want %h", change_len, k, d, l, e);
        end
      end
    end
    vectors++;
    if (bits !== want_bits) begin
      miscompares++;
      $display("FAIL frame_pattern chg=%b last_bits=%b want %b", change_len, bits, want_bits);
    end
  endtask

  task automatic test_backpressure();
    logic p, v, l, hl;
    logic [31:0] d, e, hd;
    reset_dut();
    frame_len = 16'd2;
    hd = '0;
    hl = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h5500_0000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int c = 0; c < 16; c++) begin
      cyc(1'b0, 32'd0, c[0], 1'b0, p, v, d, l);
      if (!c[0]) begin
        hd = d;
        hl = l;
      end else begin
        vectors++;
        if (d !== hd || l !== hl) begin
          miscompares++;
          $display("FAIL bp_hold cyc=%0d dat=%h last=%b want %h/%b", c, d, l, hd, hl);
        end
      end
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL bp_pop cyc=%0d dat=%h want %h", c, d, e);
        end
      end
    end
    vectors++;
    if (out_valid !== 1'b0 || level !== 5'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL bp_end vld=%b lvl=%0d left=%0d want 0/0/0", out_valid, level, sb.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic p, v, l;
    logic [31:0] d, e;
    reset_dut();
    frame_len = 16'd4;
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h7700_0000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== model_last(frame_len)) begin
          miscompares++;
          $display("FAIL mid_pop idx=%0d dat=%h want %h", i, d, e);
        end
      end
    end
    vectors++;
    if (level !== 5'd5) begin
      miscompares++;
      $display("FAIL mid_level lvl=%0d want 5", level);
    end
    reset_dut();
    frame_len = 16'd1;
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h8800_0000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0, p, v, d, l);
      if (p) begin
        e = sb.pop_front();
        vectors++;
        if (v !== 1'b1 || d !== e || l !== 1'b1 || model_last(frame_len) !== 1'b1) begin
          miscompares++;
          $display("FAIL post_reset_frame idx=%0d dat=%h last=%b want %h/1", i, d, l, e);
        end
      end
    end
  endtask

`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
  task automatic test_stats();
    logic p, v, l;
    logic [31:0] d;
    reset_dut();
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h9900_0000 + i, 1'b0, 1'b0, p, v, d, l);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hFFFF_0000 + i, 1'b0, 1'b0, p, v, d, l);
    vectors++;
    if (drop_count !== 16'd3 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL stats_count cnt=%0d ovf=%b want 3/1", drop_count, overflow);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b1, p, v, d, l);
    vectors++;
    if (drop_count !== 16'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL stats_clear cnt=%0d ovf=%b want 0/0", drop_count, overflow);
    end
  endtask
`endif

  initial begin
    m_stream = 1'b0;
    m_cnt = '0;
    m_len = '0;
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_full_simul();
    test_framing(1'b0, 7'b0100100);
    test_framing(1'b1, 7'b1010100);
    test_backpressure();
    test_reset_midframe();
`ifdef SOFTSIGN_OUT_BUFFER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/softsign_out_buffer.md
Name: softsign_out_buffer

Overview:
Downstream stage of the Softsign activation operator. It absorbs the operator's valid-only result stream (no backpressure upstream) into a small FIFO and re-emits it on a valid/ready interface toward the writeback/DMA stage. It tags frame boundaries by counting delivered elements and flags data loss when the FIFO overflows.

Parameters:
DATA_W, 32, result word width (matches the operator's output_data).
DEPTH, 16, FIFO entries; power of two, minimum 4.
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH.
CNT_W, 16, width of frame_len and the element counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
valid_in  input  1  result word present on input_data (from the Softsign stage's valid_out).
input_data  input  DATA_W  activation result word.
out_valid  output  1  output_data holds a valid word.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
output_data  output  DATA_W  head-of-FIFO word.
frame_last  output  1  qualifies output_data: last element of the current frame.
frame_len  input  CNT_W  elements per frame; sampled when a frame starts.
almost_full  output  1  level >= AF_THRESH; advisory throttle for the upstream issuer.
level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a valid_in word was dropped.
ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, level=0, out_valid=0, output_data=0, frame_last=0, almost_full=0, overflow=0, element counter=0, frame state=IDLE. Reset mid-stream discards all buffered words. No partial frame survives reset.
- Push: valid_in=1 at edge t writes input_data. The word is visible at the head (out_valid=1) from cycle t+1 at the earliest. Write-to-output latency is 1 cycle when the FIFO is empty.
- Pop: out_valid && out_ready at an edge removes the head. The next entry is presented in the following cycle with no bubble. output_data and frame_last hold stable while out_valid=1 && out_ready=0.
- Empty: out_valid=0. output_data holds its last value. out_ready is ignored.
- Full (level=DEPTH):
  - If a push and a pop happen in the same cycle, both succeed and level stays DEPTH.
  - A push without a pop is dropped, overflow is set, and the FIFO contents are unchanged.
- Simultaneous push and pop at any level: level is unchanged and pointers wrap modulo DEPTH.
- overflow: set on a dropped push and cleared by ovf_clr. If both happen in the same cycle, set wins.
- almost_full and level are registered and reflect the state after the current edge's push/pop.
- Frame FSM (advances only on a pop):
  - IDLE: on the first pop, latch frame_len into len_q and go to STREAM. The counter counts popped elements.
  - STREAM: frame_last = (cnt == len_q-1) for the head word. On a pop with frame_last=1, cnt returns to 0 and the FSM goes to IDLE, so the next pop re-samples frame_len.
  - len_q=0: frame_last never asserts. cnt wraps at 2^CNT_W and the FSM stays in STREAM until reset.
  - len_q=1: every element is a frame_last element.
  - frame_len is sampled on the pop that starts a new frame. Changes to frame_len mid-frame have no effect on the current frame.
- frame_last is combinationally derived from the registered cnt, len_q and state. It has no path from out_ready.

Optional Feature:
Macro SOFTSIGN_OUT_BUFFER_STATS_EN.
- Defined: adds output drop_count [15:0], reset to 0. It increments on every dropped push and saturates at 16'hFFFF. ovf_clr also clears it.
- Undefined: the port and counter do not exist, and all other behaviour is identical.

Test Plan:
1. Pass-through, out_ready held 1: push 0x3F000000, 0xBF000000 on consecutive cycles -> each appears one cycle later in order. level never exceeds 1.
2. Fill, no drain: 16 pushes with out_ready=0 -> level=16, almost_full=1 from the 12th push. A 17th push -> overflow=1 and contents unchanged. Drain -> 16 words in original order.
3. Full with simultaneous push and pop: level=16, valid_in=1 and out_ready=1 for 5 cycles -> level stays 16, overflow stays 0, and output order is preserved.
4. Framing: frame_len=3, stream 7 words -> frame_last on words 3 and 6 only. Change frame_len to 2 before word 4 pops -> word 5 carries frame_last, not word 6.
5. Backpressure hold: out_valid=1, out_ready toggled 0/1 every cycle -> output_data and frame_last are stable during each ready=0 cycle, with no duplicates and no losses.
6. Reset mid-frame: level=5 at cnt=2, pulse rst_n low -> level=0, out_valid=0, overflow=0, and the next pop starts a new frame using the current frame_len. With SOFTSIGN_OUT_BUFFER_STATS_EN, 3 drops followed by ovf_clr -> drop_count goes 3 then 0.
